// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel synchroniser, debouncer and edge/auto-repeat
// pulse generator for the gameplay buttons.
// Optional feature macro: BTN_AUTOREPEAT_EN. When it is defined, the repeat
// timers and btn_repeat are built. When it is undefined, btn_repeat is tied low.
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 400_000,
  parameter int REPEAT_DELAY    = 16_000_000,
  parameter int REPEAT_PERIOD   = 4_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Reject parameter sets the debounce and repeat arithmetic cannot support.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_conditioner: invalid DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic          sync1_r, sync2_r;
    state_t        state_r, state_s;
    logic [CW-1:0] count_r, count_s, count_inc_s;
    logic          level_s, press_s, release_s, repeat_s;
    logic          level_r, press_r, release_r, repeat_r;

    // Two-flop synchroniser bringing the raw pin into the clk domain.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
      end else begin
        sync1_r <= btn_raw[g];
        sync2_r <= sync1_r;
      end
    end

    // Saturating increment of the debounce counter; it never wraps.
    always_comb begin
      if (count_r == CNT_MAX) begin
        count_inc_s = CNT_MAX;
      end else begin
        count_inc_s = count_r + CNT_ONE;
      end
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= IDLE;
        count_r <= '0;
      end else begin
        state_r <= state_s;
        count_r <= count_s;
      end
    end

    // Next-state logic: accept a change only after CNT_MAX agreeing samples.
    always_comb begin
      state_s = state_r;
      count_s = count_r;
      case (state_r)
        IDLE: begin
          if (sync2_r) begin
            state_s = DEB_PRESS;
            count_s = CNT_ONE;
          end else begin
            count_s = '0;
          end
        end
        DEB_PRESS: begin
          if (!sync2_r) begin
            state_s = IDLE;
            count_s = '0;
          end else if (count_inc_s == CNT_MAX) begin
            state_s = HELD;
            count_s = '0;
          end else begin
            count_s = count_inc_s;
          end
        end
        HELD: begin
          if (!sync2_r) begin
            state_s = DEB_RELEASE;
            count_s = CNT_ONE;
          end else begin
            count_s = '0;
          end
        end
        DEB_RELEASE: begin
          if (sync2_r) begin
            state_s = HELD;
            count_s = '0;
          end else if (count_inc_s == CNT_MAX) begin
            state_s = IDLE;
            count_s = '0;
          end else begin
            count_s = count_inc_s;
          end
        end
        default: begin
          state_s = IDLE;
          count_s = '0;
        end
      endcase
    end

    // Output decode from the transition being taken this cycle.
    always_comb begin
      level_s   = (state_s == HELD) || (state_s == DEB_RELEASE);
      press_s   = (state_r == DEB_PRESS) && (state_s == HELD);
      release_s = (state_r == DEB_RELEASE) && (state_s == IDLE);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int TW = $clog2(REPEAT_DELAY + 1);
    localparam logic [TW-1:0] TMR_ONE    = TW'(1);
    localparam logic [TW-1:0] TMR_DELAY  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [TW-1:0] timer_r, timer_s, timer_inc_s;

    // Repeat timer: counts only while held and stable; reloads after each
    // repeat so subsequent pulses are REPEAT_PERIOD apart.
    always_comb begin
      timer_inc_s = timer_r + TMR_ONE;
      timer_s     = timer_r;
      repeat_s    = 1'b0;
      if (press_s || release_s) begin
        timer_s = '0;
      end else if ((state_r == HELD) && (state_s == HELD)) begin
        if (timer_inc_s == TMR_DELAY) begin
          repeat_s = 1'b1;
          timer_s  = TMR_RELOAD;
        end else begin
          timer_s = timer_inc_s;
        end
      end else begin
        timer_s = timer_r;
      end
    end

    // Repeat timer register.
    always_ff @(posedge clk) begin
      if (rst) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_s;
      end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // Registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        level_r   <= level_s;
        press_r   <= press_s;
        release_r <= release_s;
        repeat_r  <= repeat_s;
      end
    end

    assign btn_level[g]   = level_r;
    assign btn_press[g]   = press_r;
    assign btn_release[g] = release_r;
    assign btn_repeat[g]  = repeat_r;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/repeat settings.
module tb_btn_conditioner;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         r;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } vec_t;

  vec_t vecs[$];

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] l, input logic [N-1:0] p,
                         input logic [N-1:0] r, input logic [N-1:0] q);
    chk({tag, ".level"}, btn_level, l);
    chk({tag, ".press"}, btn_press, p);
    chk({tag, ".release"}, btn_release, r);
    chk({tag, ".repeat"}, btn_repeat, q);
  endtask

  task automatic add(input logic r, input logic [N-1:0] raw, input logic [N-1:0] l,
                     input logic [N-1:0] p, input logic [N-1:0] rl, input int times);
    vec_t v;
    v.r = r; v.raw = raw; v.lvl = l; v.prs = p; v.rls = rl;
    for (int i = 0; i < times; i++) vecs.push_back(v);
  endtask

  // Steps until btn_press[ch] is seen; returns the edge index or -1.
  task automatic wait_press(input int ch, output int edge_idx);
    edge_idx = -1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (btn_press[ch] === 1'b1) begin
        edge_idx = e;
        break;
      end
    end
  endtask

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe;
    logic [N-1:0] exp_rpt;

    // Vector table: inputs held for one edge, outputs expected after it.
    add(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1);  // reset
    add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    add(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 5);  // clean press ch0, edges 0..4
    add(1'b0, 3'b001, 3'b001, 3'b001, 3'b000, 1);  // edge 5
    add(1'b0, 3'b001, 3'b001, 3'b000, 3'b000, 1);  // press is one cycle
    add(1'b0, 3'b000, 3'b001, 3'b000, 3'b000, 5);  // release ch0, edges 0..4
    add(1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 1);  // edge 5
    add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    add(1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 3);  // ch2 3-cycle burst
    add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1);  // bounce low
    add(1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 5);  // steady, edges 0..4
    add(1'b0, 3'b100, 3'b100, 3'b100, 3'b000, 1);  // edge 5
    add(1'b0, 3'b100, 3'b100, 3'b000, 3'b000, 1);

    rst = 1'b1;
    btn_raw = 3'b000;
    foreach (vecs[i]) begin
      rst = vecs[i].r;
      btn_raw = vecs[i].raw;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rls, 3'b000);
    end

    // Reset while ch2 is held: everything clears at the edge.
    rst = 1'b1;
    step();
    chk_all("rst_mid_hold_ch2", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    btn_raw = 3'b000;
    step();

    // Hold ch1 and watch auto-repeat.
    btn_raw = 3'b010;
    wait_press(1, pe);
    chk_int("hold_press_edge", pe, D + 1);
    chk_all("hold_press", 3'b010, 3'b010, 3'b000, 3'b000);
    for (int off = 1; off <= 16; off++) begin
      step();
      exp_rpt = (AR && (off == RD || off == RD + RP || off == RD + 2 * RP)) ? 3'b010 : 3'b000;
      chk_all($sformatf("hold_off%0d", off), 3'b010, 3'b000, 3'b000, exp_rpt);
    end

    // Two-sample glitches low must not release.
    for (int gl = 0; gl < 2; gl++) begin
      btn_raw = 3'b000;
      step();
      step();
      btn_raw = 3'b010;
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("glitch%0d_level_c%0d", gl, c), btn_level, 3'b010);
        chk($sformatf("glitch%0d_rel_c%0d", gl, c), btn_release, 3'b000);
        chk_int("excl", int'((btn_press & btn_repeat) | (btn_press & btn_release)
                             | (btn_release & btn_repeat)), 0);
      end
    end

    // Steady release of ch1.
    btn_raw = 3'b000;
    for (int e = 0; e < D + 1; e++) begin
      step();
      chk($sformatf("rel_e%0d_release", e), btn_release, 3'b000);
      chk($sformatf("rel_e%0d_level", e), btn_level, 3'b010);
    end
    step();
    chk_all("rel_edge5", 3'b000, 3'b000, 3'b010, 3'b000);
    for (int c = 0; c < 20; c++) begin
      step();
      chk_all($sformatf("after_rel_c%0d", c), 3'b000, 3'b000, 3'b000, 3'b000);
    end

    // Reset while ch0 is HELD; a held button re-debounces after reset.
    btn_raw = 3'b001;
    wait_press(0, pe);
    chk_int("b_press_edge", pe, D + 1);
    step();
    step();
    step();
    chk("b_held_level", btn_level, 3'b001);
    rst = 1'b1;
    step();
    chk_all("b_rst", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int e = 0; e < D + 1; e++) begin
      step();
      chk_all($sformatf("b_post_rst_e%0d", e), 3'b000, 3'b000, 3'b000, 3'b000);
    end
    step();
    chk_all("b_post_rst_press", 3'b001, 3'b001, 3'b000, 3'b000);

    // Release ch0, then simultaneous presses on ch0 and ch2.
    btn_raw = 3'b000;
    for (int c = 0; c < D + 4; c++) step();
    chk("c_idle_level", btn_level, 3'b000);
    btn_raw = 3'b101;
    for (int e = 0; e < D + 1; e++) begin
      step();
      chk($sformatf("c_e%0d_press", e), btn_press, 3'b000);
    end
    step();
    chk_all("c_simul_press", 3'b101, 3'b101, 3'b000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
